fifo_to_gpio: RTL

- Readback path from PL to PS over EMIO GPIO; the opposite direction to the PS→PL GPIO-to-FIFO writer.
- PS software requests a word. The block pops one 32-bit word from a PL FIFO and loads it into a shift register.
- PS then bit-bangs the word out MSB-first: it pulses a GPIO serial clock and samples a GPIO data bit.
- Status bits (valid, empty, underflow, state) go back on the EMIO input bank so software can poll without extra AXI logic.

---
 rtl/fifo_to_gpio_pkg.sv | 39 +++
 rtl/fifo_to_gpio_if.sv | 22 ++
 rtl/fifo_to_gpio_sync_edge.sv | 27 ++
 rtl/fifo_to_gpio.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fifo_to_gpio_pkg.sv
// Shared EMIO bit map, status layout and read-path state encoding for the
// GPIO<->FIFO bridge blocks (both directions import this package).
package fifo_to_gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  // PS->PL bits: 0-3 belong to the write path, 4-6 to the read path
  localparam int WR_SCLK_BIT      = 0;
  localparam int WR_SDATA_BIT     = 1;
  localparam int WR_WRITE_BIT     = 2;
  localparam int WR_RST_BIT       = 3;
  localparam int RD_SCLK_BIT      = 4;
  localparam int RD_REQ_BIT       = 5;
  localparam int RD_CLR_UFLOW_BIT = 6;

  localparam logic [GPIO_WIDTH-1:0] WR_PATH_MASK =
    (32'd1 << WR_SCLK_BIT) | (32'd1 << WR_SDATA_BIT) |
    (32'd1 << WR_WRITE_BIT) | (32'd1 << WR_RST_BIT);
  localparam logic [GPIO_WIDTH-1:0] RD_PATH_MASK =
    (32'd1 << RD_SCLK_BIT) | (32'd1 << RD_REQ_BIT) | (32'd1 << RD_CLR_UFLOW_BIT);

  // PL->PS status bits
  localparam int ST_SDATA_BIT = 0;
  localparam int ST_VALID_BIT = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_UFLOW_BIT = 3;
  localparam int ST_STATE_LSB = 4;
  localparam int ST_STATE_MSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } rd_state_e;

endpackage

// File: rtl/fifo_to_gpio_if.sv
// FIFO-side and EMIO-side signals of the PL->PS readback path.
interface fifo_to_gpio_if
  import fifo_to_gpio_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic [GPIO_WIDTH-1:0] emio_gpio_i;
  logic [GPIO_WIDTH-1:0] emio_gpio_o;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  modport master (
    output emio_gpio_i, fifo_empty, fifo_dout,
    input  emio_gpio_o, fifo_rd_en
  );

  modport slave (
    input  emio_gpio_i, fifo_empty, fifo_dout,
    output emio_gpio_o, fifo_rd_en
  );
endinterface

// File: rtl/fifo_to_gpio_sync_edge.sv
// Multi-flop synchronizer for one GPIO input with a rising-edge pulse on the
// synchronized level.
module fifo_to_gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p  <= '0;
      level_p <= 1'b0;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], d};
      level_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = sync_p[SYNC_STAGES-1] & ~level_p;
endmodule

// File: rtl/fifo_to_gpio.sv
// Pops one FIFO word on a PS request and lets software bit-bang it out
// MSB-first over EMIO GPIO, with status readback on the same bank.
module fifo_to_gpio
  import fifo_to_gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic          clk,
  input  logic          rst,
  fifo_to_gpio_if.slave bus
);
  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int WAIT_W = 2;

  rd_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  uflow, uflow_nxt, uflow_set;

  logic sclk_lvl, sclk_rise;
  logic req_lvl, req_rise;
  logic clr_lvl, clr_rise;
  logic unused_gpio;

  fifo_to_gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.emio_gpio_i[RD_SCLK_BIT]),
    .level(sclk_lvl), .rise(sclk_rise)
  );

  fifo_to_gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .rst(rst), .d(bus.emio_gpio_i[RD_REQ_BIT]),
    .level(req_lvl), .rise(req_rise)
  );

  fifo_to_gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst(rst), .d(bus.emio_gpio_i[RD_CLR_UFLOW_BIT]),
    .level(clr_lvl), .rise(clr_rise)
  );

  // Write-path GPIO bits and the unused synchronized levels are not ours
  assign unused_gpio = ^{bus.emio_gpio_i & (WR_PATH_MASK | ~RD_PATH_MASK), sclk_lvl, clr_lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      uflow     <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      wait_cnt  <= wait_nxt;
      uflow     <= uflow_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    wait_nxt    = wait_cnt;
    uflow_set   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_rise) begin
          if (bus.fifo_empty) uflow_set = 1'b1;
          else                state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        state_nxt = ST_WAIT;
        wait_nxt  = WAIT_W'(RD_LATENCY - 1);
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_nxt = ST_LOAD;
        else                wait_nxt  = wait_cnt - 1'b1;
      end
      ST_LOAD: begin
        // A request dropped during POP/WAIT lets the pop finish, then drops the word
        bit_cnt_nxt = '0;
        if (!req_lvl) begin
          state_nxt = ST_IDLE;
          shift_nxt = '0;
        end else begin
          state_nxt = ST_SHIFT;
          shift_nxt = bus.fifo_dout;
        end
      end
      ST_SHIFT: begin
        if (!req_lvl) begin
          state_nxt = ST_IDLE;
          shift_nxt = '0;
        end else if (sclk_rise) begin
          shift_nxt   = shift_reg << 1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!req_lvl) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A fresh underflow outranks a simultaneous clear
    if (uflow_set)     uflow_nxt = 1'b1;
    else if (clr_rise) uflow_nxt = 1'b0;
    else               uflow_nxt = uflow;
  end

  assign bus.fifo_rd_en = (state == ST_POP);

  always_comb begin
    bus.emio_gpio_o                             = '0;
    bus.emio_gpio_o[ST_SDATA_BIT]               = shift_reg[DATA_WIDTH-1];
    bus.emio_gpio_o[ST_VALID_BIT]               = (state == ST_SHIFT);
    bus.emio_gpio_o[ST_EMPTY_BIT]               = bus.fifo_empty;
    bus.emio_gpio_o[ST_UFLOW_BIT]               = uflow;
    bus.emio_gpio_o[ST_STATE_MSB:ST_STATE_LSB]  = state;
  end
endmodule
